// File: rtl/usb_cdc_pkg.sv
// rtl/usb_cdc_pkg.sv - shared CDC-ACM notification constants, FSM encoding and message byte helper
//
// Purpose : constants for the SERIAL_STATE interrupt-IN notification, the
//           serial-state bit layout, the notifier FSM encoding and a helper
//           that returns byte N of the 10-byte notification.
// Ports   : none (package)
package usb_cdc_pkg;

  // Notification header fields
  localparam logic [7:0]  CDC_BMREQ_NOTIFY       = 8'hA1;
  localparam logic [7:0]  CDC_NOTIF_SERIAL_STATE = 8'h20;
  localparam logic [15:0] SERIAL_STATE_LEN       = 16'd2;
  localparam logic [11:0] NOTIFY_MSG_LEN         = 12'd10;
  localparam logic [3:0]  NOTIFY_LAST_IDX        = 4'd9;

  // Bit positions inside i_serial_state / the UART-state bitmap:
  // [1:0] DCD, DSR levels; [6:2] break, ring, framing, parity, overrun events
  localparam int SS_LVL_LSB = 0;
  localparam int SS_LVL_MSB = 1;
  localparam int SS_EVT_LSB = 2;
  localparam int SS_EVT_MSB = 6;

  // Notifier FSM encoding
  typedef logic [1:0] notify_state_t;
  localparam notify_state_t ST_IDLE  = 2'd0;
  localparam notify_state_t ST_ARMED = 2'd1;
  localparam notify_state_t ST_SEND  = 2'd2;
  localparam notify_state_t ST_DONE  = 2'd3;

  // Byte idx of the little-endian SERIAL_STATE notification.
  function automatic logic [7:0] notify_byte(input logic [3:0]  idx,
                                             input logic [15:0] ifnum,
                                             input logic [7:0]  bitmap);
    logic [7:0] b;
    case (idx)
      4'd0:    b = CDC_BMREQ_NOTIFY;
      4'd1:    b = CDC_NOTIF_SERIAL_STATE;
      4'd2:    b = 8'h00;                 // wValue low
      4'd3:    b = 8'h00;                 // wValue high
      4'd4:    b = ifnum[7:0];            // wIndex low
      4'd5:    b = ifnum[15:8];           // wIndex high
      4'd6:    b = SERIAL_STATE_LEN[7:0];
      4'd7:    b = SERIAL_STATE_LEN[15:8];
      4'd8:    b = bitmap;
      default: b = 8'h00;                 // bitmap high byte
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cdc_serial_state_tracker.sv
// rtl/cdc_serial_state_tracker.sv - UART status accumulator, level compare and snapshot for SERIAL_STATE
//
// Purpose : accumulates UART event pulses, remembers the levels last reported
//           to the host, captures the snapshot carried by an in-flight
//           notification and hands its events back if the transfer aborts.
// Ports   :
//   i_clk, i_reset        clock, async active-high reset
//   i_enable              gate for o_pending
//   i_serial_state [6:0]  [1:0] DCD/DSR levels, [6:2] event pulses
//   i_snapshot            capture levels and acc|events, clear accumulator
//   i_restore             fold the snapshot events back into the accumulator
//   i_commit              snapshot levels become the last-reported levels
//   o_pending             something new to report
//   o_snap_lvl [1:0]      captured levels
//   o_snap_evt [4:0]      captured events
module cdc_serial_state_tracker
  import usb_cdc_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [6:0] i_serial_state,
  input  logic       i_snapshot,
  input  logic       i_restore,
  input  logic       i_commit,
  output logic       o_pending,
  output logic [1:0] o_snap_lvl,
  output logic [4:0] o_snap_evt
);

  logic [1:0] lvl;
  logic [4:0] evt;

  logic [4:0] acc_q,      acc_d;
  logic [1:0] last_lvl_q, last_lvl_d;
  logic [1:0] snap_lvl_q, snap_lvl_d;
  logic [4:0] snap_evt_q, snap_evt_d;

  assign lvl = i_serial_state[SS_LVL_MSB:SS_LVL_LSB];
  assign evt = i_serial_state[SS_EVT_MSB:SS_EVT_LSB];

  always_comb begin
    acc_d      = acc_q | evt;
    last_lvl_d = last_lvl_q;
    snap_lvl_d = snap_lvl_q;
    snap_evt_d = snap_evt_q;
    if (i_snapshot) begin
      // An event arriving on the capture cycle rides in the snapshot, so the
      // accumulator can start clean.
      snap_lvl_d = lvl;
      snap_evt_d = acc_q | evt;
      acc_d      = 5'd0;
    end else if (i_restore) begin
      // Aborted transfer: nothing reached the host, keep those events owed.
      acc_d = acc_q | evt | snap_evt_q;
    end
    if (i_commit) begin
      last_lvl_d = snap_lvl_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q      <= 5'd0;
      last_lvl_q <= 2'b00;
      snap_lvl_q <= 2'b00;
      snap_evt_q <= 5'd0;
    end else begin
      acc_q      <= acc_d;
      last_lvl_q <= last_lvl_d;
      snap_lvl_q <= snap_lvl_d;
      snap_evt_q <= snap_evt_d;
    end
  end

  assign o_pending  = i_enable & ((lvl != last_lvl_q) | (acc_q != 5'd0));
  assign o_snap_lvl = snap_lvl_q;
  assign o_snap_evt = snap_evt_q;

endmodule

// File: rtl/usb_cdc_serial_state_notify.sv
// rtl/usb_cdc_serial_state_notify.sv - CDC-ACM SERIAL_STATE notifier on the interrupt-IN endpoint
//
// Purpose : watches UART status and, when levels change or events occur,
//           offers the 10-byte SERIAL_STATE notification on NOTIFY_EP, with a
//           minimum spacing of HOLDOFF_CYCLES between delivered notifications.
// Ports   :
//   i_clk, i_reset        clock, async active-high reset
//   i_enable              configured / UART enabled
//   i_serial_state [6:0]  DCD/DSR levels and event pulses
//   i_usb_endpt [3:0]     endpoint addressed by the controller
//   i_usb_txact           IN transfer active
//   i_usb_txpop           current o_usb_txdat byte consumed
//   i_usb_txpktfin        packet finished and ACKed
//   o_usb_txcork          1 = NAK IN tokens
//   o_usb_txlen [11:0]    packet length (10)
//   o_usb_txdat [7:0]     current notification byte
//   o_notify_sent         one-cycle pulse per delivered notification
module usb_cdc_serial_state_notify
  import usb_cdc_pkg::*;
#(
  parameter logic [3:0]  NOTIFY_EP      = 4'd3,
  parameter logic [15:0] INTERFACE_NUM  = 16'd0,
  parameter int          HOLDOFF_CYCLES = 60000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [6:0]  i_serial_state,
  input  logic [3:0]  i_usb_endpt,
  input  logic        i_usb_txact,
  input  logic        i_usb_txpop,
  input  logic        i_usb_txpktfin,
  output logic        o_usb_txcork,
  output logic [11:0] o_usb_txlen,
  output logic [7:0]  o_usb_txdat,
  output logic        o_notify_sent
);

  localparam int HW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLDOFF_RELOAD = HW'(HOLDOFF_CYCLES - 1);

  logic sel, act, pop, fin, act_rise;
  logic pending, holdoff_expired;
  logic snapshot, restore, commit;
  logic [1:0] snap_lvl;
  logic [4:0] snap_evt;
  logic [7:0] bitmap;

  notify_state_t state_q, state_d;
  logic [3:0]    idx_q,   idx_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic          sent_q,  sent_d;
  logic          act_q;

  // Controller strobes only count when they address our endpoint.
  assign sel      = (i_usb_endpt == NOTIFY_EP);
  assign act      = sel & i_usb_txact;
  assign pop      = sel & i_usb_txpop;
  assign fin      = sel & i_usb_txpktfin;
  assign act_rise = act & ~act_q;

  assign holdoff_expired = (holdoff_q == '0);

  cdc_serial_state_tracker u_tracker (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_serial_state (i_serial_state),
    .i_snapshot     (snapshot),
    .i_restore      (restore),
    .i_commit       (commit),
    .o_pending      (pending),
    .o_snap_lvl     (snap_lvl),
    .o_snap_evt     (snap_evt)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sent_d    = 1'b0;
    snapshot  = 1'b0;
    restore   = 1'b0;
    commit    = 1'b0;
    holdoff_d = holdoff_expired ? holdoff_q : holdoff_q - HW'(1);
    case (state_q)
      ST_IDLE: begin
        if (pending && holdoff_expired) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (act_rise) begin
          state_d  = ST_SEND;
          snapshot = 1'b1;
          idx_d    = 4'd0;
        end else if (!pending && !act) begin
          // Level reverted before the host asked: nothing left to say.
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (fin) begin
          state_d   = ST_DONE;
          commit    = 1'b1;
          sent_d    = 1'b1;
          holdoff_d = HOLDOFF_RELOAD;
          idx_d     = 4'd0;
        end else if (!act) begin
          // Transfer ended without ACK: retry with the same events.
          state_d = ST_ARMED;
          restore = 1'b1;
          idx_d   = 4'd0;
        end else if (pop && (idx_q != NOTIFY_LAST_IDX)) begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (!act) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      holdoff_q <= '0;
      sent_q    <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      holdoff_q <= holdoff_d;
      sent_q    <= sent_d;
      act_q     <= act;
    end
  end

  assign bitmap = {1'b0, snap_evt, snap_lvl};

  // Zero-latency byte mux: the controller may pop on the cycle it samples.
  always_comb begin
    o_usb_txdat = CDC_BMREQ_NOTIFY;
    if (state_q == ST_SEND) begin
      o_usb_txdat = notify_byte(idx_q, INTERFACE_NUM, bitmap);
    end
  end

  assign o_usb_txcork  = ~((state_q == ST_ARMED) | (state_q == ST_SEND));
  assign o_usb_txlen   = NOTIFY_MSG_LEN;
  assign o_notify_sent = sent_q;

endmodule
